moore_ssm_sched: RTL and testbench

MOORE_SSM_SCHED -- requirements
Module: moore_ssm_sched

---
 rtl/moore_ssm_sched.sv | 112 +++++++++++
 tb/tb_moore_ssm_sched.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/moore_ssm_sched.sv
// Two-requester round-robin scheduler: each granted word is scanned LSB-first through a 1101 Moore detector.
// Result follows grant by W+1 cycles; define SSM_STATE_CARRY_EN to keep detector state across words.
module moore_ssm_sched #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic [W-1:0]  req0_data,
  input  logic          req1_valid,
  input  logic [W-1:0]  req1_data,
  output logic          req0_ready,
  output logic          req1_ready,
  output logic          busy,
  output logic          res_valid,
  output logic          res_id,
  output logic [CW-1:0] res_hits
);
  localparam int NW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} ctl_t;
  typedef enum logic [2:0] {A, B, C, D, E} det_t;

  ctl_t          ctl, ctl_nxt;
  det_t          det, det_nxt;
  logic [W-1:0]  sr;
  logic [CW-1:0] hits;
  logic [NW-1:0] cnt;
  logic          last_id;
  logic          cur_id;
  logic          gnt0, gnt1;
  logic          last_bit;

  // Grants only in IDLE; last_id resets to 1 so requester 0 wins the first tie.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (ctl == IDLE && !rst) begin
      if (req0_valid && req1_valid) begin
        gnt0 = last_id;
        gnt1 = !last_id;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign last_bit = (cnt == NW'(W - 1));

  always_comb begin
    ctl_nxt = ctl;
    case (ctl)
      IDLE:    if (gnt0 || gnt1) ctl_nxt = SHIFT;
      SHIFT:   if (last_bit) ctl_nxt = DONE;
      DONE:    ctl_nxt = IDLE;
      default: ctl_nxt = IDLE;
    endcase
  end

  always_comb begin
    det_nxt = A;
    case (det)
      A:       det_nxt = sr[0] ? B : A;
      B:       det_nxt = sr[0] ? C : A;
      C:       det_nxt = sr[0] ? C : D;
      D:       det_nxt = sr[0] ? E : A;
      E:       det_nxt = sr[0] ? C : A;
      default: det_nxt = A;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl     <= IDLE;
      det     <= A;
      sr      <= '0;
      hits    <= '0;
      cnt     <= '0;
      last_id <= 1'b1;
      cur_id  <= 1'b0;
    end else begin
      ctl <= ctl_nxt;
      if (gnt0 || gnt1) begin
        sr      <= gnt0 ? req0_data : req1_data;
        hits    <= '0;
        cnt     <= '0;
        cur_id  <= gnt1;
        last_id <= gnt1;
`ifdef SSM_STATE_CARRY_EN
        det     <= det;
`else
        det     <= A;
`endif
      end else if (ctl == SHIFT) begin
        sr  <= sr >> 1;
        det <= det_nxt;
        cnt <= cnt + NW'(1);
        if (det_nxt == E) hits <= hits + CW'(1);
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign busy       = (ctl != IDLE);
  assign res_valid  = (ctl == DONE);
  assign res_id     = res_valid ? cur_id : 1'b0;
  assign res_hits   = res_valid ? hits : '0;

endmodule

// File: tb/tb_moore_ssm_sched.sv
// Scoreboard bench for moore_ssm_sched: directed scenarios followed by random traffic.
module tb_moore_ssm_sched;
  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic [W-1:0]  req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          busy, res_valid, res_id;
  logic [CW-1:0] res_hits;

  moore_ssm_sched #(.W(W), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_data(req1_data),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .busy(busy), .res_valid(res_valid), .res_id(res_id), .res_hits(res_hits)
  );

  always #5 clk = ~clk;

  typedef struct {bit id; int hits; int due;} exp_t;
  exp_t sb[$];

  int       checks = 0;
  int       errors = 0;
  int       cyc = 0;
  int       rem = 0;
  bit       last = 1'b1;
  logic [3:0] hist = 4'b0;
  bit       mg0 = 1'b0, mg1 = 1'b0;
  bit       w0, w1;
  bit       refill = 1'b0;
  int       last_hits = -1;
  int       last_res_id = -1;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d cyc=%0d", name, act, exp, cyc);
    end
  endtask

  // Counts windows equal to 1101 in the bit stream seen so far (oldest bit first).
  function automatic int scan(input logic [W-1:0] w);
    int h = 0;
    for (int i = 0; i < W; i++) begin
      hist = {hist[2:0], w[i]};
      if (hist == 4'b1101) h++;
    end
    return h;
  endfunction

  // Reference model: decides grants, predicts busy and the result of each word.
  always @(negedge clk) begin
    mg0 = 1'b0;
    mg1 = 1'b0;
    if (rst) begin
      chk("reset_outputs", {req0_ready, req1_ready, busy, res_valid, res_id, res_hits}, 0);
      rem  = 0;
      last = 1'b1;
      hist = 4'b0;
      sb.delete();
    end else begin
      chk("busy", busy, rem != 0);
      if (rem == 0) begin
        w0 = req0_valid && (!req1_valid || last);
        w1 = req1_valid && (!req0_valid || !last);
        chk("ready0", req0_ready, w0);
        chk("ready1", req1_ready, w1);
        if (w0 || w1) begin
`ifndef SSM_STATE_CARRY_EN
          hist = 4'b0;
`endif
          sb.push_back('{w1, scan(w1 ? req1_data : req0_data), cyc + W + 1});
          last = w1;
          rem  = W + 1;
          mg0  = w0;
          mg1  = w1;
        end
      end else begin
        chk("ready_held_off", {req0_ready, req1_ready}, 0);
        rem--;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  always @(negedge clk) begin
    if (!rst) begin
      if (res_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_res actual=res_valid expected=none cyc=%0d", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("res_id", res_id, e.id);
          chk("res_hits", res_hits, e.hits);
          chk("res_cycle", cyc, e.due);
          last_hits   = int'(res_hits);
          last_res_id = int'(res_id);
        end
      end else if (sb.size() != 0 && sb[0].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_res actual=none expected_cycle=%0d cyc=%0d", sb[0].due, cyc);
        void'(sb.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (mg0) req0_valid = refill;
    if (mg1) req1_valid = refill;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((req0_valid || req1_valid || rem != 0 || sb.size() != 0) && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout actual=busy expected=idle cyc=%0d", cyc);
    end
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0;    req1_data = '0;
    repeat (3) step();
    rst = 1'b0;
    step();

    req0_data = 8'h0B; req0_valid = 1'b1;
    wait_idle();
    chk("s0B_id", last_res_id, 0);
    chk("s0B_hits", last_hits, 1);

    req1_data = 8'h5B; req1_valid = 1'b1;
    wait_idle();
    chk("s5B_id", last_res_id, 1);
    chk("s5B_hits", last_hits, 2);

    refill = 1'b1;
    req0_data = 8'h00; req1_data = 8'h00;
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (40) step();
    refill = 1'b0;
    wait_idle();

    req0_data = 8'hC0; req0_valid = 1'b1;
    wait_idle();
    req0_data = 8'h02; req0_valid = 1'b1;
    wait_idle();
`ifdef SSM_STATE_CARRY_EN
    chk("carry_hits", last_hits, 1);
`else
    chk("carry_hits", last_hits, 0);
`endif

    req0_data = 8'hFF; req0_valid = 1'b1;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    req0_data = 8'hAA; req1_data = 8'h55;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    chk("abort_grant0", req0_ready, 1);
    wait_idle();

    req0_data = 8'h33; req0_valid = 1'b1;
    repeat (3) step();
    req1_data = 8'h6D; req1_valid = 1'b1;
    wait_idle();
    chk("late_req1_id", last_res_id, 1);

    for (int k = 0; k < 1500; k++) begin
      step();
      if (!req0_valid && ($urandom % 4 == 0)) begin
        req0_data = ($urandom % 3 == 0) ? 8'hDB : W'($urandom);
        req0_valid = 1'b1;
      end else if (req0_valid && !mg0 && ($urandom % 16 == 0)) begin
        req0_valid = 1'b0;
      end
      if (!req1_valid && ($urandom % 4 == 0)) begin
        req1_data = ($urandom % 3 == 0) ? 8'h6D : W'($urandom);
        req1_valid = 1'b1;
      end else if (req1_valid && !mg1 && ($urandom % 16 == 0)) begin
        req1_valid = 1'b0;
      end
    end
    wait_idle();
    chk("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
